// File: rtl/mem_access_unit.sv
// mem_access_unit: owns PC, OldPC, IR and MDR for the multicycle core and runs
// every fetch/load/store over a req/ack memory bus with wait states. Holds the
// control FSM via stall until the access completes or times out.
module mem_access_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        ir_write,
  input  logic        address_source,
  input  logic        memory_write,
  input  logic        pc_write,
  input  logic [31:0] result,
  input  logic [31:0] write_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic [31:0] pc,
  output logic [31:0] old_pc,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] mdr,
  output logic        bus_error
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  // Last BUSY count value; an unacknowledged cycle at this count aborts.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state, w_next_state;
  logic [7:0]  r_count;
  logic [31:0] r_pc, r_old_pc, r_instr, r_mdr;
  logic        r_bus_error;
  logic [31:0] r_addr, r_wdata;
  logic        r_we, r_is_fetch;

  logic        w_busy, w_start, w_active, w_timeout, w_complete, w_abort;
  logic        w_is_fetch, w_we;

  // Fetch has priority over a data access requested in the same cycle.
  assign w_busy     = (r_state == S_BUSY);
  assign w_start    = ir_write | address_source;
  assign w_active   = resetn & (w_busy | w_start);
  assign w_timeout  = w_busy & ~mem_ack & (r_count == TIMEOUT_LAST);
  assign w_complete = w_active & mem_ack;
  assign w_abort    = resetn & w_timeout;
  assign w_is_fetch = w_busy ? r_is_fetch : ir_write;
  assign w_we       = w_busy ? r_we : (~ir_write & memory_write);

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // pre-edge values regardless of block evaluation order.
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state: enter BUSY on an unacknowledged start, leave on ack or timeout.
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned
    // (which would infer a latch).
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_start && !mem_ack)      w_next_state = S_BUSY;
      S_BUSY: if (mem_ack || w_timeout)     w_next_state = S_IDLE;
      default:                              w_next_state = S_IDLE;
    endcase
  end

  // Bus and stall outputs: live inputs in IDLE, latched request in BUSY.
  always_comb begin
    mem_req   = w_active;
    mem_we    = w_we;
    mem_addr  = w_busy ? r_addr : (ir_write ? r_pc : result);
    mem_wdata = w_busy ? r_wdata : write_data;
    stall     = w_active & ~mem_ack & ~w_timeout;
  end

  // Request latches, captured when an access is launched from IDLE.
  always_ff @(posedge clock) begin
    // NOTE: no reset here on purpose; these are only read in BUSY, which is
    // reachable only through the launch that writes them.
    if (r_state == S_IDLE && w_start) begin
      r_addr     <= ir_write ? r_pc : result;
      r_wdata    <= write_data;
      r_we       <= ~ir_write & memory_write;
      r_is_fetch <= ir_write;
    end
  end

  // Architectural registers, wait counter and sticky error flag.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_pc        <= RESET_PC;
      r_old_pc    <= RESET_PC;
      r_instr     <= NOP_INSTR;
      r_mdr       <= '0;
      r_bus_error <= 1'b0;
      r_count     <= '0;
    end else begin
      if (r_state == S_IDLE) r_count <= '0;
      else                   r_count <= r_count + 8'd1;

      if (w_complete) begin
        if (w_is_fetch) begin
          r_instr  <= mem_rdata;
          r_old_pc <= r_pc;
        end else if (!w_we) begin
          r_mdr <= mem_rdata;
        end
      end

      if (w_abort) begin
        r_bus_error <= 1'b1;
        if (r_is_fetch) r_instr <= NOP_INSTR;
      end

      if (pc_write && !stall) r_pc <= result;
    end
  end

  assign pc        = r_pc;
  assign old_pc    = r_old_pc;
  assign instr     = r_instr;
  assign mdr       = r_mdr;
  assign bus_error = r_bus_error;
  assign opcode    = r_instr[6:0];
  assign funct3    = r_instr[14:12];
  assign funct7    = r_instr[31:25];

endmodule
